// File: rtl/key_pio_pkg.sv
// rtl/key_pio_pkg.sv - shared constants and helpers for the debounced key PIO
package key_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd4;
    localparam logic [2:0] ADDR_RAW          = 3'd5;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Counter width for a given debounce length; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce counter, edge pulses
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   raw          asynchronous key input
//   sync         synchronised (undebounced) level
//   stable       debounced level
//   rise, fall   one-cycle pulses in the cycle after stable goes 0->1 / 1->0
module key_debounce_ch
    import key_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_BIT       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    // Counter only runs while sync disagrees with stable, so it tops out at
    // CNT_LAST and is cleared there; it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= RESET_BIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
                rise   <= sync;
                fall   <= ~sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_pio_debounce.sv
// rtl/key_pio_debounce.sv - debounced key PIO with edge capture and interrupt
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   address, chipselect, read,  register interface (write when chipselect & ~write_n)
//   write_n, writedata, readdata
//   in_port                     raw asynchronous key inputs (active low)
//   irq                         level interrupt: any captured edge that is unmasked
module key_pio_debounce
    import key_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] capture_clr;
    logic [WIDTH-1:0] capture_set;
    logic [31:0]      rd_mux;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_BIT       (RESET_LEVEL[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (in_port[i]),
            .sync   (sync[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign wr               = chipselect & ~write_n;
    assign wdata            = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign capture_clr      = (wr && address == ADDR_EDGE_CAPTURE) ? wdata : '0;
    assign capture_set      = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_en      <= '0;
            fall_en      <= '1;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr && address == ADDR_RISE_EN)  rise_en  <= wdata;
            if (wr && address == ADDR_FALL_EN)  fall_en  <= wdata;
            if (wr && address == ADDR_IRQ_MASK) irq_mask <= wdata;
            // Set term is ORed after the clear so a same-cycle event is never lost.
            edge_capture <= (edge_capture & ~capture_clr) | capture_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:         rd_mux[WIDTH-1:0] = stable;
            ADDR_RISE_EN:      rd_mux[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
            ADDR_FALL_EN:      rd_mux[WIDTH-1:0] = fall_en;
            ADDR_RAW:          rd_mux[WIDTH-1:0] = sync;
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (chipselect && read) begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_key_pio_debounce.sv
// tb/tb_key_pio_debounce.sv - directed self-checking bench for key_pio_debounce
module tb_key_pio_debounce;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int total;
    int bad;

    logic [31:0] d;
    logic [31:0] rst_exp [8];

    key_pio_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] q);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        q          = readdata;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] v);
        address    = a;
        writedata  = v;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        rst_exp    = '{32'hF, 32'h0, 32'h0, 32'h0, 32'hF, 32'hF, 32'h0, 32'h0};

        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        step(2);
        reset = 1'b0;

        // Reset values of every address
        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), d);
            check($sformatf("rst_addr%0d", a), d, rst_exp[a]);
        end
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        // Glitch: three low cycles never reach the acceptance count
        in_port[0] = 1'b0;
        step(3);
        in_port[0] = 1'b1;
        step(10);
        reg_read(3'd0, d);
        check("glitch_data", d, 32'hF);
        reg_read(3'd3, d);
        check("glitch_capture", d, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Clean press: stable updates on edge 6, readdata shows it from edge 7,
        // the fall pulse is captured on edge 7 and irq follows immediately.
        reg_write(3'd2, 32'h1);
        in_port[0] = 1'b0;
        address    = 3'd0;
        chipselect = 1'b1;
        read       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("press_data_e%0d", k), readdata, (k <= 6) ? 32'hF : 32'hE);
            check($sformatf("press_irq_e%0d", k), {31'b0, irq}, (k <= 6) ? 32'h0 : 32'h1);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        reg_read(3'd3, d);
        check("press_capture", d, 32'h1);
        reg_read(3'd5, d);
        check("press_raw", d, 32'hE);

        // Release with rising capture disabled, then write-1-to-clear
        in_port[0] = 1'b1;
        step(10);
        reg_read(3'd0, d);
        check("release_data", d, 32'hF);
        reg_read(3'd3, d);
        check("release_capture", d, 32'h1);
        reg_write(3'd3, 32'h1);
        reg_read(3'd3, d);
        check("clear_capture", d, 32'h0);
        check("clear_irq", {31'b0, irq}, 32'h0);

        // Clear write lands on the same edge the bit-1 fall pulse is captured
        in_port[1] = 1'b0;
        step(6);
        reg_write(3'd3, 32'h2);
        reg_read(3'd3, d);
        check("set_wins_capture", d, 32'h2);
        check("set_wins_irq_masked", {31'b0, irq}, 32'h0);
        reg_write(3'd3, 32'h0);
        reg_read(3'd3, d);
        check("write0_keeps", d, 32'h2);
        reg_write(3'd2, 32'h2);
        check("mask_bit1_irq", {31'b0, irq}, 32'h1);
        reg_write(3'd4, 32'h0);
        reg_read(3'd3, d);
        check("fall_en_change_keeps", d, 32'h2);
        reg_read(3'd4, d);
        check("fall_en_rw", d, 32'h0);
        reg_write(3'd1, 32'h5);
        reg_read(3'd1, d);
        check("rise_en_rw", d, 32'h5);
        reg_write(3'd6, 32'hF);
        reg_read(3'd6, d);
        check("addr6_ignored", d, 32'h0);
        in_port[1] = 1'b1;
        step(10);

        // Reset after three low cycles on key 2, released with key still low
        in_port[2] = 1'b0;
        step(3);
        reset = 1'b1;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        step(2);
        reset      = 1'b0;
        chipselect = 1'b1;
        read       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            address = (k <= 3) ? 3'd3 : 3'd0;
            @(negedge clk);
            if (k <= 3)
                check($sformatf("midrst_capture_e%0d", k), readdata, 32'h0);
            else
                check($sformatf("midrst_data_e%0d", k), readdata, (k <= 6) ? 32'hF : 32'hB);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        reg_read(3'd3, d);
        check("midrst_capture_after", d, 32'h4);
        check("midrst_irq_after", {31'b0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_pio_debounce.md
KEY_PIO_DEBOUNCE -- requirements
Module: key_pio_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of key channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level change, minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, minimum 2.
REQ-004 Parameter RESET_LEVEL, default all ones (WIDTH bits): reset value of the synchroniser and debounced state (keys released, active low).
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  3  Avalon-MM register word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 read  in  1  read strobe.
REQ-010 write_n  in  1  active-low write strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  read data; bits above WIDTH read as 0.
REQ-013 in_port  in  WIDTH  raw, asynchronous key inputs.
REQ-014 irq  out  1  level interrupt request.

Function
REQ-015 Register map:
- 0 DATA (RO): debounced state.
- 1 RISE_EN (RW): per-channel rising-edge capture enable.
- 2 IRQ_MASK (RW).
- 3 EDGE_CAPTURE (write-1-to-clear).
- 4 FALL_EN (RW): per-channel falling-edge capture enable.
- 5 RAW (RO): synchronised, undebounced input.
- 6-7: read 0; writes ignored.
REQ-016 A write occurs when chipselect=1 and write_n=0; RW registers take writedata[WIDTH-1:0] on that edge.
REQ-017 readdata is registered: it presents the addressed register on the clock edge after chipselect=1 and read=1, then holds until the next read.
REQ-018 Each in_port bit passes through a SYNC_STAGES flip-flop chain; the output of the chain is sync[i].
REQ-019 Per-channel counter, width $clog2(DEBOUNCE_CYCLES):
- if sync[i] equals stable[i], the counter clears to 0;
- otherwise it increments;
- when it equals DEBOUNCE_CYCLES-1 while sync[i] differs from stable[i], stable[i] takes sync[i] and the counter clears.
REQ-020 Any mismatch shorter than DEBOUNCE_CYCLES consecutive cycles (a glitch) shall leave stable[i] unchanged. The counter never wraps.
REQ-021 Latency: a clean level change on in_port[i] appears in DATA exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
REQ-022 rise[i] and fall[i] are single-cycle pulses, asserted in the cycle after stable[i] changes 0->1 or 1->0 respectively.
REQ-023 edge_capture[i] sets on the clock edge where (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]) is true.
REQ-024 A write of 1 to EDGE_CAPTURE bit i clears bit i; writing 0 leaves it unchanged.
REQ-025 If a clear and a capture event hit the same bit in the same cycle, the set wins.
REQ-026 irq = |(edge_capture & IRQ_MASK), combinational from registers, with no added latency.
REQ-027 Changing RISE_EN, FALL_EN or IRQ_MASK does not alter bits already captured.

Reset
REQ-028 While reset=1, the following values hold immediately and asynchronously:
- sync and stable = RESET_LEVEL;
- counters = 0; rise and fall = 0;
- readdata = 0; IRQ_MASK = 0; RISE_EN = 0; FALL_EN = all ones;
- edge_capture = 0; irq = 0.
REQ-029 Reset asserted mid-debounce discards the partial count. No edge pulse shall be generated on reset release.

Structure
REQ-030 Shared package key_pio_pkg holds:
- register address constants ADDR_DATA..ADDR_RAW;
- the default DEBOUNCE_CYCLES value;
- the counter-width function.
REQ-031 One sub-module, key_debounce_ch, holds the per-channel synchroniser, counter, stable bit and rise/fall pulses. It is instantiated WIDTH times in a generate loop.

Verification (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-032 Reset sequence, then read each address 0..7:
- DATA=0xF, RISE_EN=0x0, IRQ_MASK=0x0, EDGE_CAPTURE=0x0, FALL_EN=0xF;
- addresses 6-7 read 0;
- irq=0.
REQ-033 Glitch rejection: in_port[0] held low for 3 cycles, then high -> DATA stays 0xF and EDGE_CAPTURE stays 0.
REQ-034 Clean press: write IRQ_MASK=0x1, then drive in_port[0] low and hold ->
- DATA reads 0xE 6 cycles after the change;
- EDGE_CAPTURE=0x1 one cycle later;
- irq=1.
REQ-035 Release with RISE_EN=0: in_port[0] returns high -> DATA=0xF and no new capture. Then write EDGE_CAPTURE=0x1 -> capture=0, irq=0.
REQ-036 Simultaneous clear and set: write EDGE_CAPTURE=0x2 on the same cycle that the bit-1 fall pulse occurs -> bit 1 reads 1.
REQ-037 Reset mid-operation: assert reset after in_port[2] has been low 3 cycles, release with in_port[2] still low ->
- DATA=0xF during and after reset, until 6 cycles post-release, then 0xB;
- no capture at release;
- one capture after the debounced fall.
